// File: rtl/frame_scanout.sv
// frame_scanout: VGA raster timing plus the read side of the filtered frame buffer.
// Build macro SCANOUT_THRESHOLD_EN switches the colour path from grayscale to a THRESH binarizer.
module frame_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int RD_LATENCY = 2,
    parameter int THRESH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        buf_valid,
    output logic [18:0] rd_addr,
    input  logic [3:0]  rd_data,
    output logic        frame_read_done,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_ACT = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_END = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SS  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_END = VW'(V_TOTAL - 1);

    localparam logic [18:0] ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);
    localparam logic [18:0] ADDR_PRE  = 19'(H_ACTIVE * V_ACTIVE - 2);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("frame_scanout: RD_LATENCY must be 1..4");
    end
    if (THRESH < 0 || THRESH > 15) begin : g_bad_thresh
        $error("frame_scanout: THRESH must be 0..15");
    end

    logic [HW-1:0]       h_cnt;
    logic [VW-1:0]       v_cnt;
    logic                show_frame;
    logic                armed;
    logic [RD_LATENCY:0] hs_pipe;
    logic [RD_LATENCY:0] vs_pipe;
    logic [RD_LATENCY:0] bl_pipe;
    logic [3:0]          pix;
    logic [3:0]          pix_in;

    logic active;
    logic raw_hs;
    logic raw_vs;
    logic frame_wrap;
    logic frame_start;

    always_comb begin
        active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        raw_hs      = !((h_cnt >= H_SS) && (h_cnt < H_SE));
        raw_vs      = !((v_cnt >= V_SS) && (v_cnt < V_SE));
        frame_wrap  = (h_cnt == H_END) && (v_cnt == V_END);
        frame_start = (h_cnt == '0) && (v_cnt == '0);
    end

    always_comb begin
`ifdef SCANOUT_THRESHOLD_EN
        pix_in = (rd_data >= 4'(THRESH)) ? 4'hF : 4'h0;
`else
        pix_in = rd_data;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            rd_addr         <= '0;
            frame_read_done <= 1'b0;
            show_frame      <= 1'b0;
            armed           <= 1'b0;
            hs_pipe         <= '1;
            vs_pipe         <= '1;
            bl_pipe         <= '1;
            pix             <= '0;
        end else begin
            if (h_cnt == H_END) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_END) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end

            // Address advances only on active pixels and saturates, so it simply holds across blanking.
            if (frame_wrap) begin
                rd_addr <= '0;
            end else if (active && rd_addr != ADDR_LAST) begin
                rd_addr <= rd_addr + 19'd1;
            end
            frame_read_done <= active && (rd_addr == ADDR_PRE);

            // The frame right after reset is never shown: armed only becomes set at the first wrap.
            if (frame_wrap) begin
                armed <= 1'b1;
            end
            if (frame_start) begin
                show_frame <= buf_valid && armed;
            end

            hs_pipe <= {hs_pipe[RD_LATENCY-1:0], raw_hs};
            vs_pipe <= {vs_pipe[RD_LATENCY-1:0], raw_vs};
            bl_pipe <= {bl_pipe[RD_LATENCY-1:0], !active};

            // Stage RD_LATENCY-1 holds the blank flag of the pixel whose data is on rd_data now.
            pix <= (show_frame && !bl_pipe[RD_LATENCY-1]) ? pix_in : 4'h0;
        end
    end

    assign hsync = hs_pipe[RD_LATENCY];
    assign vsync = vs_pipe[RD_LATENCY];
    assign blank = bl_pipe[RD_LATENCY];
    assign vga_r = pix;
    assign vga_g = pix;
    assign vga_b = pix;

endmodule

// File: tb/tb_frame_scanout.sv
// Self-checking bench for frame_scanout on a reduced raster, against a position-based reference model.
module tb_frame_scanout;

    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3;
    localparam int L  = 2;
    localparam int TH = 8;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int LAST  = HA * VA - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        buf_valid = 1'b0;
    logic [18:0] rd_addr;
    logic [3:0]  rd_data;
    logic [3:0]  q1;
    logic        frame_read_done;
    logic        hsync, vsync, blank;
    logic [3:0]  vga_r, vga_g, vga_b;

    logic [3:0]  mem [0:LAST];
    logic        shown [0:63];
    int          n;
    int          vectors = 0;
    int          errors  = 0;

    frame_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .RD_LATENCY(L), .THRESH(TH)
    ) dut (
        .clk(clk), .rst(rst), .buf_valid(buf_valid), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_read_done(frame_read_done),
        .hsync(hsync), .vsync(vsync), .blank(blank),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    // Two-cycle BRAM
    always @(posedge clk) begin
        q1      <= mem[rd_addr];
        rd_data <= q1;
    end

    // Reference model: everything derived from the cycle index since reset release.
    function automatic int pos_h(int m); return (m % FRAME) % HT; endfunction
    function automatic int pos_v(int m); return (m % FRAME) / HT; endfunction

    function automatic int e_addr(int c);
        int h, v, a;
        h = pos_h(c);
        v = pos_v(c);
        if (v >= VA) return LAST;
        a = v * HA + ((h < HA) ? h : HA);
        return (a > LAST) ? LAST : a;
    endfunction

    function automatic logic e_done(int c);
        return (pos_h(c) == HA - 1) && (pos_v(c) == VA - 1);
    endfunction

    function automatic logic e_hs(int c);
        int m = c - (L + 1);
        if (m < 0) return 1'b1;
        return !(pos_h(m) >= HA + HFP && pos_h(m) < HA + HFP + HS);
    endfunction

    function automatic logic e_vs(int c);
        int m = c - (L + 1);
        if (m < 0) return 1'b1;
        return !(pos_v(m) >= VA + VFP && pos_v(m) < VA + VFP + VS);
    endfunction

    function automatic logic e_blank(int c);
        int m = c - (L + 1);
        if (m < 0) return 1'b1;
        return !(pos_h(m) < HA && pos_v(m) < VA);
    endfunction

    function automatic logic [3:0] e_pix(logic [3:0] d);
`ifdef SCANOUT_THRESHOLD_EN
        return (int'(d) >= TH) ? 4'hF : 4'h0;
`else
        return d;
`endif
    endfunction

    function automatic logic [3:0] e_rgb(int c);
        int m = c - (L + 1);
        if (m < 0) return 4'h0;
        if (!(pos_h(m) < HA && pos_v(m) < VA)) return 4'h0;
        if (!shown[m / FRAME]) return 4'h0;
        return e_pix(mem[pos_v(m) * HA + pos_h(m)]);
    endfunction

    task automatic advance(input logic bv);
        @(posedge clk);
        #1;
        n++;
        buf_valid = bv;
        if (n % FRAME == 0 && n / FRAME < 64) shown[n / FRAME] = bv;
    endtask

    task automatic clear_model();
        n = 0;
        for (int i = 0; i < 64; i++) shown[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        buf_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vectors += 6;
        if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", hsync); end
        if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", vsync); end
        if (blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b exp 1", blank); end
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", {vga_r, vga_g, vga_b}); end
        if (rd_addr !== 19'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", rd_addr); end
        if (frame_read_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_read_done); end
        rst = 1'b0;
        clear_model();
    endtask

    task automatic test_sync_timing();
        int hs_low, vs_low, hs_fall, vs_fall;
        logic prev_hs, prev_vs;
        hs_low = 0; vs_low = 0; hs_fall = -1; vs_fall = -1;
        prev_hs = hsync; prev_vs = vsync;
        for (int k = 0; k < 2 * FRAME; k++) begin
            advance(1'b1);
            vectors += 3;
            if (hsync !== e_hs(n)) begin errors++; $display("FAIL sync_hsync n=%0d got %b exp %b", n, hsync, e_hs(n)); end
            if (vsync !== e_vs(n)) begin errors++; $display("FAIL sync_vsync n=%0d got %b exp %b", n, vsync, e_vs(n)); end
            if (blank !== e_blank(n)) begin errors++; $display("FAIL sync_blank n=%0d got %b exp %b", n, blank, e_blank(n)); end
            if (hsync === 1'b0) hs_low++;
            if (vsync === 1'b0) vs_low++;
            if (prev_hs === 1'b1 && hsync === 1'b0) begin
                if (hs_fall >= 0) begin
                    vectors++;
                    if (n - hs_fall != HT) begin errors++; $display("FAIL hsync_period got %0d exp %0d", n - hs_fall, HT); end
                end
                hs_fall = n;
            end
            if (prev_vs === 1'b1 && vsync === 1'b0) begin
                if (vs_fall >= 0) begin
                    vectors++;
                    if (n - vs_fall != FRAME) begin errors++; $display("FAIL vsync_period got %0d exp %0d", n - vs_fall, FRAME); end
                end
                vs_fall = n;
            end
            prev_hs = hsync;
            prev_vs = vsync;
        end
        vectors += 2;
        if (hs_low != 2 * VT * HS) begin errors++; $display("FAIL hsync_low_total got %0d exp %0d", hs_low, 2 * VT * HS); end
        if (vs_low != 2 * VS * HT) begin errors++; $display("FAIL vsync_low_total got %0d exp %0d", vs_low, 2 * VS * HT); end
    endtask

    task automatic test_addressing();
        int pulses, max_addr;
        pulses = 0; max_addr = 0;
        for (int k = 0; k < FRAME; k++) begin
            advance(1'b1);
            vectors += 2;
            if (rd_addr !== 19'(e_addr(n))) begin errors++; $display("FAIL addr n=%0d got %0d exp %0d", n, rd_addr, e_addr(n)); end
            if (frame_read_done !== e_done(n)) begin errors++; $display("FAIL done n=%0d got %b exp %b", n, frame_read_done, e_done(n)); end
            if (frame_read_done === 1'b1) pulses++;
            if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        end
        vectors += 2;
        if (pulses != 1) begin errors++; $display("FAIL done_count got %0d exp 1", pulses); end
        if (max_addr != LAST) begin errors++; $display("FAIL addr_max got %0d exp %0d", max_addr, LAST); end
    endtask

    task automatic test_latency();
        int t0, first_vis;
        logic [18:0] prev_addr;
        t0 = -1; first_vis = -1;
        prev_addr = rd_addr;
        for (int k = 0; k < FRAME + 10; k++) begin
            advance(1'b1);
            vectors++;
            if ({vga_r, vga_g, vga_b} !== {3{e_rgb(n)}}) begin
                errors++; $display("FAIL latency_rgb n=%0d got %h exp %h", n, {vga_r, vga_g, vga_b}, {3{e_rgb(n)}});
            end
            if (t0 < 0 && prev_addr == 19'(LAST) && rd_addr == 19'd0) t0 = n;
            if (t0 >= 0 && first_vis < 0 && blank === 1'b0) first_vis = n;
            if (t0 >= 0 && n >= t0 + L + 1 && n < t0 + L + 5) begin
                vectors++;
                if (vga_r !== e_pix(4'(n - t0 - L - 1))) begin
                    errors++; $display("FAIL first_pixels n=%0d got %h exp %h", n, vga_r, e_pix(4'(n - t0 - L - 1)));
                end
            end
            prev_addr = rd_addr;
        end
        vectors++;
        if (t0 < 0 || first_vis - t0 != L + 1) begin
            errors++; $display("FAIL first_visible_delay got %0d exp %0d", first_vis - t0, L + 1);
        end
    endtask

    task automatic test_arming();
        int f, nz_off, nz_on, pulses, m;
        logic bv;
        nz_off = 0; nz_on = 0; pulses = 0;
        for (int k = 0; k < FRAME && (n % FRAME) != FRAME - 1; k++) advance(1'b1);
        f = (n + 1) / FRAME;
        for (int k = 0; k < 2 * FRAME + L + 1; k++) begin
            bv = !((n + 1) / FRAME == f && ((n + 1) % FRAME) < FRAME / 2);
            advance(bv);
            vectors++;
            if ({vga_r, vga_g, vga_b} !== {3{e_rgb(n)}}) begin
                errors++; $display("FAIL arming_rgb n=%0d got %h exp %h", n, {vga_r, vga_g, vga_b}, {3{e_rgb(n)}});
            end
            m = n - (L + 1);
            if (m / FRAME == f && vga_r !== 4'h0) nz_off++;
            if (m / FRAME == f + 1 && vga_r !== 4'h0) nz_on++;
        end
        vectors += 2;
        if (nz_off != 0) begin errors++; $display("FAIL unarmed_frame_black got %0d nonzero exp 0", nz_off); end
        if (nz_on == 0) begin errors++; $display("FAIL armed_frame_shown got %0d nonzero exp >0", nz_on); end

        for (int k = 0; k < FRAME && pos_v(n) != 5; k++) advance(1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors += 4;
        if (rd_addr !== 19'd0) begin errors++; $display("FAIL midreset_addr got %0d exp 0", rd_addr); end
        if ({hsync, vsync, blank} !== 3'b111) begin errors++; $display("FAIL midreset_sync got %b exp 111", {hsync, vsync, blank}); end
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin errors++; $display("FAIL midreset_rgb got %h exp 000", {vga_r, vga_g, vga_b}); end
        if (frame_read_done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b exp 0", frame_read_done); end
        rst = 1'b0;
        clear_model();
        nz_off = 0;
        for (int k = 0; k < FRAME + 5; k++) begin
            advance(1'b1);
            vectors += 3;
            if (rd_addr !== 19'(e_addr(n))) begin errors++; $display("FAIL restart_addr n=%0d got %0d exp %0d", n, rd_addr, e_addr(n)); end
            if (blank !== e_blank(n)) begin errors++; $display("FAIL restart_blank n=%0d got %b exp %b", n, blank, e_blank(n)); end
            if ({vga_r, vga_g, vga_b} !== {3{e_rgb(n)}}) begin
                errors++; $display("FAIL restart_rgb n=%0d got %h exp %h", n, {vga_r, vga_g, vga_b}, {3{e_rgb(n)}});
            end
            if (frame_read_done === 1'b1) pulses++;
            if (n < FRAME && vga_r !== 4'h0) nz_off++;
        end
        vectors += 2;
        if (nz_off != 0) begin errors++; $display("FAIL first_frame_black got %0d nonzero exp 0", nz_off); end
        if (pulses != 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", pulses); end
    endtask

    task automatic test_threshold();
        logic [3:0] thr_exp [0:2];
        int m;
`ifdef SCANOUT_THRESHOLD_EN
        thr_exp[0] = 4'h0; thr_exp[1] = 4'hF; thr_exp[2] = 4'hF;
`else
        thr_exp[0] = 4'h7; thr_exp[1] = 4'h8; thr_exp[2] = 4'hF;
`endif
        for (int k = 0; k < FRAME && pos_v(n) != VA + 1; k++) advance(1'b1);
        for (int i = 0; i <= LAST; i++) mem[i] = 4'($urandom_range(0, 15));
        mem[0] = 4'd7; mem[1] = 4'd8; mem[2] = 4'd15;
        for (int k = 0; k < FRAME; k++) begin
            advance(1'b1);
            vectors++;
            if ({vga_r, vga_g, vga_b} !== {3{e_rgb(n)}}) begin
                errors++; $display("FAIL thresh_rgb n=%0d got %h exp %h", n, {vga_r, vga_g, vga_b}, {3{e_rgb(n)}});
            end
            m = n - (L + 1);
            if (m >= 0 && m % FRAME < 3 && shown[m / FRAME]) begin
                vectors++;
                if (vga_r !== thr_exp[m % FRAME]) begin
                    errors++; $display("FAIL thresh_value idx=%0d got %h exp %h", m % FRAME, vga_r, thr_exp[m % FRAME]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic bv;
        bv = 1'b1;
        for (int k = 0; k < 4 * FRAME; k++) begin
            if ($urandom_range(0, 49) == 0) bv = !bv;
            advance(bv);
            if (pos_v(n) == VA + 1 && pos_h(n) == 0)
                for (int i = 0; i <= LAST; i++) mem[i] = 4'($urandom_range(0, 15));
            vectors += 6;
            if (rd_addr !== 19'(e_addr(n))) begin errors++; $display("FAIL rand_addr n=%0d got %0d exp %0d", n, rd_addr, e_addr(n)); end
            if (frame_read_done !== e_done(n)) begin errors++; $display("FAIL rand_done n=%0d got %b exp %b", n, frame_read_done, e_done(n)); end
            if (hsync !== e_hs(n)) begin errors++; $display("FAIL rand_hsync n=%0d got %b exp %b", n, hsync, e_hs(n)); end
            if (vsync !== e_vs(n)) begin errors++; $display("FAIL rand_vsync n=%0d got %b exp %b", n, vsync, e_vs(n)); end
            if (blank !== e_blank(n)) begin errors++; $display("FAIL rand_blank n=%0d got %b exp %b", n, blank, e_blank(n)); end
            if ({vga_r, vga_g, vga_b} !== {3{e_rgb(n)}}) begin
                errors++; $display("FAIL rand_rgb n=%0d got %h exp %h", n, {vga_r, vga_g, vga_b}, {3{e_rgb(n)}});
            end
        end
    endtask

    initial begin
        for (int i = 0; i <= LAST; i++) mem[i] = 4'(i);
        clear_model();
        test_reset();
        test_sync_timing();
        test_addressing();
        test_latency();
        test_arming();
        test_threshold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
